// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates an active-low row strobe, synchronizes the columns,
// reports the lowest pressed code per frame and debounces it. Define KEYPAD_REPEAT_EN for auto-repeat pulses.
module keypad_scan #(
  parameter int unsigned SCAN_DIV = 25000,
  parameter int unsigned DB_CNT   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [4:0] key,
  output logic [4:0] key_pulse
);

  localparam int unsigned DIV_W   = $clog2(SCAN_DIV);
  localparam logic [3:0]  DB_LAST = 4'(DB_CNT);

  typedef enum logic [1:0] {IDLE, CHK_PRESS, HELD, CHK_REL} state_t;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row;
  logic             dwell_end;
  logic             frame_end;
  logic [3:0]       col_s1, col_s2;
  logic [1:0]       row_col;
  logic             row_hit;
  logic             acc_valid, scan_valid;
  logic [3:0]       acc_code, scan_code;

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d, cnt_inc;
  logic [3:0] cand, cand_d;
  logic [4:0] key_d, pulse_d;
  logic       match;
`ifdef KEYPAD_REPEAT_EN
  logic [5:0] rep_cnt, rep_d, rep_inc;
`endif

  assign dwell_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (row == 2'd3);

  // Row strobe and dwell timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      row     <= 2'd0;
      row_n   <= 4'b1110;
    end else if (dwell_end) begin
      div_cnt <= '0;
      row     <= row + 2'd1;
      row_n   <= ~(4'b0001 << (row + 2'd1));
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Column synchronizer; idle level is released (high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  // Lowest pressed code so far in this frame, including the row being sampled now
  always_comb begin
    row_hit = (col_s2 != 4'b1111);
    row_col = 2'd0;
    if      (!col_s2[0]) row_col = 2'd0;
    else if (!col_s2[1]) row_col = 2'd1;
    else if (!col_s2[2]) row_col = 2'd2;
    else if (!col_s2[3]) row_col = 2'd3;
    if (row == 2'd0 || !acc_valid) begin
      scan_valid = row_hit;
      scan_code  = {row, row_col};
    end else begin
      scan_valid = acc_valid;
      scan_code  = acc_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_valid <= 1'b0;
      acc_code  <= 4'd0;
    end else if (dwell_end) begin
      acc_valid <= scan_valid;
      acc_code  <= scan_code;
    end
  end

  // Debounce state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cand      <= 4'd0;
      key       <= 5'd0;
      key_pulse <= 5'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= 6'd0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cand      <= cand_d;
      key       <= key_d;
      key_pulse <= pulse_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_d;
`endif
    end
  end

  // Debounce next-state; only frame ends can move it
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    key_d   = key;
    pulse_d = 5'd0;
    cnt_inc = cnt + 4'd1;
    match   = scan_valid && (scan_code == cand);
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_cnt;
    rep_inc = rep_cnt + 6'd1;
`endif
    if (frame_end) begin
      case (state)
        IDLE: begin
          key_d = 5'd0;
          if (scan_valid) begin
            state_d = CHK_PRESS;
            cand_d  = scan_code;
            cnt_d   = 4'd1;
          end
        end
        CHK_PRESS: begin
          if (!scan_valid) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (match) begin
            if (cnt_inc == DB_LAST) begin
              state_d = HELD;
              cnt_d   = 4'd0;
              key_d   = {1'b1, cand};
              pulse_d = {1'b1, cand};
`ifdef KEYPAD_REPEAT_EN
              rep_d   = 6'd0;
`endif
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cand_d = scan_code;
            cnt_d  = 4'd1;
          end
        end
        HELD: begin
          if (!match) begin
            state_d = CHK_REL;
            cnt_d   = 4'd1;
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            if (rep_inc == 6'd32 || rep_inc == 6'd40) pulse_d = {1'b1, cand};
            rep_d = (rep_inc == 6'd40) ? 6'd32 : rep_inc;
          end
`endif
        end
        CHK_REL: begin
          if (match) begin
            state_d = HELD;
            cnt_d   = 4'd0;
          end else if (cnt_inc == DB_LAST) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            key_d   = 5'd0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = 6'd0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DB_CNT=3 (16-cycle frames) and a behavioral keypad.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [4:0]  key;
  logic [4:0]  key_pulse;
  logic [15:0] pressed;
  int          checks = 0;
  int          errors = 0;

  keypad_scan #(.SCAN_DIV(4), .DB_CNT(3)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n), .key(key), .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column to its row while that row is driven low
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4 + c] && !row_n[r]) col_n[c] = 1'b0;
  end

  // Advance to just after the next frame-end edge (row_n wraps 0111 -> 1110)
  task automatic wait_frame();
    logic [3:0] prev;
    bit seen;
    prev = row_n;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (prev == 4'b0111 && row_n == 4'b1110) seen = 1;
      prev = row_n;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_frame: no frame end within 40 cycles, row_n=%b", row_n);
    end
  endtask

  task automatic chk_key(input string name, input logic [4:0] exp_key, input logic [4:0] exp_pulse);
    checks++;
    if (key !== exp_key) begin
      errors++;
      $display("FAIL %s key: got %h expected %h", name, key, exp_key);
    end
    checks++;
    if (key_pulse !== exp_pulse) begin
      errors++;
      $display("FAIL %s key_pulse: got %h expected %h", name, key_pulse, exp_pulse);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows [4];
    exp_rows[0] = 4'b1110; exp_rows[1] = 4'b1101; exp_rows[2] = 4'b1011; exp_rows[3] = 4'b0111;
    rst = 1'b1;
    pressed = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (row_n !== 4'b1110) begin errors++; $display("FAIL reset row_n: got %b expected 1110", row_n); end
    chk_key("reset", 5'h00, 5'h00);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (row_n !== exp_rows[k % 4]) begin
        errors++;
        $display("FAIL row_step%0d row_n: got %b expected %b", k, row_n, exp_rows[k % 4]);
      end
    end
    chk_key("idle_frame", 5'h00, 5'h00);
  endtask

  task automatic test_press();
    bit extra_pulse = 0;
    bit key_lost = 0;
    pressed = 16'h0002;
    wait_frame(); chk_key("press_f1", 5'h00, 5'h00);
    wait_frame(); chk_key("press_f2", 5'h00, 5'h00);
    wait_frame(); chk_key("press_f3", 5'h11, 5'h11);
    @(posedge clk); #1;
    chk_key("press_after", 5'h11, 5'h00);
    for (int i = 0; i < 47; i++) begin
      @(posedge clk); #1;
      if (key_pulse !== 5'h00) extra_pulse = 1;
      if (key !== 5'h11) key_lost = 1;
    end
    checks++;
    if (extra_pulse) begin errors++; $display("FAIL press_no_repeat: got pulse expected none"); end
    checks++;
    if (key_lost) begin errors++; $display("FAIL press_hold: key left 11 expected 11"); end
  endtask

  task automatic test_release();
    wait_frame();
    pressed = 16'h0000;
    wait_frame(); chk_key("glitch_rel", 5'h11, 5'h00);
    pressed = 16'h0002;
    wait_frame(); chk_key("glitch_back", 5'h11, 5'h00);
    pressed = 16'h0000;
    wait_frame(); chk_key("rel_f1", 5'h11, 5'h00);
    wait_frame(); chk_key("rel_f2", 5'h11, 5'h00);
    wait_frame(); chk_key("rel_f3", 5'h00, 5'h00);
  endtask

  task automatic test_bounce();
    bit any_pulse = 0;
    pressed = 16'h0008;
    wait_frame(); chk_key("bounce_f1", 5'h00, 5'h00);
    pressed = 16'h0000;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      if (key_pulse !== 5'h00) any_pulse = 1;
    end
    checks++;
    if (any_pulse) begin errors++; $display("FAIL bounce_pulse: got pulse expected none"); end
    chk_key("bounce_end", 5'h00, 5'h00);
  endtask

  task automatic test_multi_key();
    wait_frame();
    pressed = 16'h0048;
    wait_frame(); chk_key("multi_f1", 5'h00, 5'h00);
    wait_frame(); chk_key("multi_f2", 5'h00, 5'h00);
    wait_frame(); chk_key("multi_f3", 5'h13, 5'h13);
    pressed = 16'h0000;
    repeat (3) wait_frame();
    chk_key("multi_rel", 5'h00, 5'h00);
  endtask

  task automatic test_reset_mid();
    pressed = 16'h0040;
    wait_frame();
    wait_frame(); chk_key("mid_chk", 5'h00, 5'h00);
    rst = 1'b1;
    #1;
    checks++;
    if (row_n !== 4'b1110) begin errors++; $display("FAIL mid_rst row_n: got %b expected 1110", row_n); end
    chk_key("mid_rst", 5'h00, 5'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_frame(); chk_key("fresh_f1", 5'h00, 5'h00);
    wait_frame(); chk_key("fresh_f2", 5'h00, 5'h00);
    wait_frame(); chk_key("fresh_f3", 5'h16, 5'h16);
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    int hits [$];
    pressed = 16'h0000;
    repeat (3) wait_frame();
    pressed = 16'h0002;
    for (int f = 1; f <= 50; f++) begin
      wait_frame();
      if (key_pulse === 5'h11) hits.push_back(f);
    end
    checks++;
    if (hits.size() != 3 || hits[0] != 3 || hits[1] != 35 || hits[2] != 43) begin
      errors++;
      $display("FAIL repeat_frames: got %0d pulses %p expected frames 3 35 43", hits.size(), hits);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_multi_key();
    test_reset_mid();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 25000, giving clk cycles each row is driven (dwell); legal range >= 4.
REQ-002 The block SHALL have parameter DB_CNT, default 4, giving consecutive identical frame results needed to accept a press or release; legal range 2..15.
REQ-003 The block SHALL have port clk, input, 1, system clock (pixel clock domain of the graphics stage).
REQ-004 The block SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-005 The block SHALL have port col_n, input, 4, keypad column lines, active-low, pulled up, asynchronous to clk.
REQ-006 The block SHALL have port row_n, output, 4, keypad row drive, active-low one-hot.
REQ-007 The block SHALL have port key, output, 5, debounced level: bit4 = key valid, bits3:0 = code = row*4 + col.
REQ-008 The block SHALL have port key_pulse, output, 5, one-cycle copy of key on each accepted press, else 0.

Function
REQ-009 col_n SHALL pass through a 2-flop synchronizer before any use.
REQ-010 Row counter SHALL drive rows 0,1,2,3 in order, each for exactly SCAN_DIV cycles, wrapping 3->0; row_n = ~(1 << row).
REQ-011 Synchronized columns SHALL be sampled only on the last cycle of each row dwell.
REQ-012 A frame SHALL be one full pass of rows 0..3; frame result is evaluated on the last sample cycle of row 3 (frame end).
REQ-013 Frame result SHALL be the lowest code among pressed keys (lowest row, then lowest column); NONE if no key pressed.
REQ-014 Debounce FSM states: IDLE, CHK_PRESS, HELD, CHK_REL; a frame counter (4 bits) and a 4-bit candidate register.
REQ-015 IDLE: key = 0; at frame end with result code C -> CHK_PRESS, cand = C, cnt = 1; NONE -> stay.
REQ-016 CHK_PRESS: result == cand -> cnt+1; when cnt+1 == DB_CNT -> HELD, key = {1,cand}, key_pulse = {1,cand}; result NONE -> IDLE; other code -> cand = new, cnt = 1.
REQ-017 HELD: key held at {1,cand}; any result != cand (including NONE or another key) -> CHK_REL, cnt = 1.
REQ-018 CHK_REL: key unchanged; result == cand -> HELD (glitch, no pulse); result != cand -> cnt+1; when cnt+1 == DB_CNT -> IDLE, key = 0; no pulse on release.
REQ-019 Key change without full release SHALL pass CHK_REL -> IDLE, then full press debounce for the new key.
REQ-020 key and key_pulse SHALL be registered and update on the clk edge following the frame-end sample; key_pulse is high exactly one cycle per accepted press.
REQ-021 Outside frame ends FSM, cnt and cand SHALL hold.

Reset
REQ-022 While rst is high: row = 0, row_n = 4'b1110, dwell counter = 0, synchronizer flops = 4'b1111, state = IDLE, cnt = 0, cand = 0, key = 0, key_pulse = 0.
REQ-023 Assertion of rst mid-operation SHALL clear all outputs immediately; after release scanning restarts at row 0 and any partial debounce is discarded.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN: when defined, in HELD a repeat counter SHALL emit key_pulse = {1,cand} after 32 consecutive HELD frame ends, then every 8 frame ends; counter clears on leaving HELD and is frozen in CHK_REL.
REQ-025 When KEYPAD_REPEAT_EN is undefined, key_pulse SHALL fire only once per accepted press and no repeat logic SHALL exist.

Verification (SCAN_DIV=4, DB_CNT=3, frame = 16 cycles)
REQ-026 Reset: assert rst -> row_n = 4'b1110, key = 0, key_pulse = 0; release -> row_n steps 1110,1101,1011,0111 every 4 cycles.
REQ-027 Hold row0/col1 steady -> key = 5'h11 and key_pulse = 5'h11 for 1 cycle after 3rd frame end; no further pulse (macro off).
REQ-028 Bounce: row0/col3 present 1 frame then absent -> key = 0, key_pulse never nonzero.
REQ-029 Release after HELD 5'h11 -> key stays 5'h11 through 2 frame ends, becomes 0 at 3rd; 1-frame release glitch -> key stays 5'h11, no pulse.
REQ-030 Codes 3 and 6 pressed together -> key = 5'h13; reset asserted during CHK_PRESS -> key = 0 and a fresh 3-frame debounce required.
REQ-031 KEYPAD_REPEAT_EN defined, hold code 1 for 50 frames -> pulses at frames 3, 35, 43 after first press frame (initial + repeats).
